sync_fifo_fwft: RTL and testbench

- Synchronous single-clock FIFO with first-word-fall-through (FWFT) read semantics.
- The head word is always presented on rdata_o whenever empty_o is low; ren_i acknowledges/pops that word, it does not request it.
- Sits between a producer issuing wen_i/wdata_i and a consumer that samples rdata_o directly; exports full/empty/almost-empty flags and an occupancy count.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_regfile.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 88 ++++++++
 tb/tb_sync_fifo_fwft.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the first-word-fall-through FIFO.
package fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 8;
endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one combinational read port.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Contents are deliberately left unreset; the top masks reads when empty.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with first-word-fall-through reads: the head word sits on
// rdata_o whenever the FIFO is non-empty and ren_i pops it.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(FIFO_DEPTH),
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ren_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  aempty_o,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AEMPT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_FULL);
  assign aempty_o = (count_q <= CNT_AEMPT);
  assign count_o  = count_q;

  assign rd_acc = ren_i && !empty_o;
  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign wr_acc = wen_i && (!full_o || rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wptr_q),
    .wdata_i(wdata_i),
    .raddr_i(rptr_q),
    .rdata_o(head_data)
  );

  assign rdata_o = empty_o ? '0 : head_data;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: fixed vector table, directed
// corner sequences and a randomized run against a queue reference model.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ren_i = 1'b0;
  logic          wen_i = 1'b0;
  logic [DW-1:0] wdata_i = '0;
  logic [DW-1:0] rdata_o;
  logic          empty_o, aempty_o, full_o;
  logic [AW:0]   count_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];

  typedef struct {
    logic          wen;
    logic [DW-1:0] wdata;
    logic          ren;
    int            exp_count;
    int            exp_rdata;
    logic          exp_empty;
    logic          exp_full;
    logic          exp_aempty;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_fwft #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .AEMPTY_LEVEL(AEL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ren_i   (ren_i),
    .rdata_o (rdata_o),
    .empty_o (empty_o),
    .aempty_o(aempty_o),
    .wen_i   (wen_i),
    .wdata_i (wdata_i),
    .full_o  (full_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference queue by the same rules, then
  // sample 1 time unit after the rising edge.
  task automatic step(input logic wen, input logic [DW-1:0] wd, input logic ren);
    bit rd, wr;
    wen_i   = wen;
    wdata_i = wd;
    ren_i   = ren;
    rd = ren && (model_q.size() > 0);
    wr = wen && ((model_q.size() < DEPTH) || rd);
    @(posedge clk);
    #1;
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back(wd);
    wen_i = 1'b0;
    ren_i = 1'b0;
  endtask

  task automatic model_check(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, ".full"}, 32'(full_o), 32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(aempty_o), 32'(n <= AEL));
    chk({tag, ".rdata"}, 32'(rdata_o), (n > 0) ? 32'(model_q[0]) : 32'd0);
  endtask

  task automatic add(input logic w, input int wd, input logic r, input int c,
                     input int rd, input logic e, input logic f, input logic ae);
    vec_t v;
    v.wen = w; v.wdata = DW'(wd); v.ren = r;
    v.exp_count = c; v.exp_rdata = rd;
    v.exp_empty = e; v.exp_full = f; v.exp_aempty = ae;
    vecs.push_back(v);
  endtask

  initial begin
    //  wen data ren | count rdata empty full aempty
    add(1, 1,  0,   1, 1,  0, 0, 1);
    add(0, 0,  1,   0, 0,  1, 0, 1);
    add(0, 0,  1,   0, 0,  1, 0, 1);
    add(1, 2,  1,   1, 2,  0, 0, 1);
    add(1, 3,  1,   1, 3,  0, 0, 1);
    add(1, 4,  0,   2, 3,  0, 0, 0);
    add(1, 5,  0,   3, 3,  0, 0, 0);
    add(1, 6,  0,   4, 3,  0, 0, 0);
    add(1, 7,  0,   5, 3,  0, 0, 0);
    add(1, 8,  0,   6, 3,  0, 0, 0);
    add(1, 9,  0,   7, 3,  0, 0, 0);
    add(1, 10, 0,   8, 3,  0, 1, 0);
    add(1, 11, 0,   8, 3,  0, 1, 0);
    add(1, 12, 1,   8, 4,  0, 1, 0);
    add(0, 0,  1,   7, 5,  0, 0, 0);
    add(0, 0,  1,   6, 6,  0, 0, 0);
    add(0, 0,  1,   5, 7,  0, 0, 0);
    add(0, 0,  1,   4, 8,  0, 0, 0);
    add(0, 0,  1,   3, 9,  0, 0, 0);
    add(0, 0,  1,   2, 10, 0, 0, 0);
    add(0, 0,  1,   1, 12, 0, 0, 1);
    add(0, 0,  1,   0, 0,  1, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.count", 32'(count_o), 32'd0);
    chk("reset.empty", 32'(empty_o), 32'd1);
    chk("reset.aempty", 32'(aempty_o), 32'd1);
    chk("reset.full", 32'(full_o), 32'd0);
    chk("reset.rdata", 32'(rdata_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].wen, vecs[i].wdata, vecs[i].ren);
      chk($sformatf("vec%0d.count", i), 32'(count_o), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.rdata", i), 32'(rdata_o), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d.empty", i), 32'(empty_o), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.full", i), 32'(full_o), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d.aempty", i), 32'(aempty_o), 32'(vecs[i].exp_aempty));
    end

    // Streaming: one word in, one word out every cycle.
    step(1'b1, 8'd1, 1'b0);
    chk("stream.first", 32'(rdata_o), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      step(1'b1, DW'(k), 1'b1);
      chk($sformatf("stream.rdata%0d", k), 32'(rdata_o), 32'(k));
      chk($sformatf("stream.count%0d", k), 32'(count_o), 32'd1);
      chk($sformatf("stream.full%0d", k), 32'(full_o), 32'd0);
    end
    step(1'b0, 8'd0, 1'b1);
    chk("stream.drain_empty", 32'(empty_o), 32'd1);
    chk("stream.drain_count", 32'(count_o), 32'd0);
    step(1'b0, 8'd0, 1'b1);
    chk("stream.idle_count", 32'(count_o), 32'd0);
    chk("stream.idle_rdata", 32'(rdata_o), 32'd0);

    // Fill, overfill, then pop-with-push at full, then drain across the wrap.
    for (int k = 3; k <= 10; k++) step(1'b1, DW'(k), 1'b0);
    model_check("fill");
    for (int k = 11; k <= 15; k++) step(1'b1, DW'(k), 1'b0);
    model_check("overfill");
    step(1'b1, 8'd11, 1'b1);
    chk("fullrw.rdata", 32'(rdata_o), 32'd4);
    chk("fullrw.count", 32'(count_o), 32'd8);
    for (int k = 4; k <= 11; k++) begin
      chk($sformatf("drain.word%0d", k), 32'(rdata_o), 32'(k));
      step(1'b0, 8'd0, 1'b1);
    end
    model_check("drained");

    // Randomized traffic with stalls, exercising many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), DW'($urandom), 1'($urandom_range(0, 99) < 50));
      model_check("rand");
    end
    while (model_q.size() > 0) begin
      step(1'b0, 8'd0, 1'b1);
      model_check("rand_drain");
    end

    // Asynchronous reset mid-cycle with five words held.
    for (int k = 0; k < 5; k++) step(1'b1, DW'(8'h40 + k), 1'b0);
    model_check("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    chk("midrst.count", 32'(count_o), 32'd0);
    chk("midrst.empty", 32'(empty_o), 32'd1);
    chk("midrst.rdata", 32'(rdata_o), 32'd0);
    chk("midrst.full", 32'(full_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5a, 1'b0);
    model_check("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
